// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit start validation and framing check
module uart_rx #(
    parameter int CLKS_PER_BIT = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frm_err,
    output logic       rx_bsy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state, state_n;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sh;

    logic cnt_clr, shift_en, idx_clr, idx_inc, load, valid_n, err_n;

    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
        load     = 1'b0;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_clr = 1'b1;
                end
            end
            START: begin
                // a start bit that is no longer low at mid-bit was a glitch
                if (cnt == HALF_M1) begin
                    cnt_clr = 1'b1;
                    if (!rx_s) begin
                        state_n = DATA;
                        idx_clr = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        load    = 1'b1;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // hold off until the line returns high so a break reports once
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_frm_err <= 1'b0;
        end else begin
            rx_m       <= rx;
            rx_s       <= rx_m;
            state      <= state_n;
            rx_valid   <= valid_n;
            rx_frm_err <= err_n;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (state == START || state == DATA || state == STOP) begin
                cnt <= cnt + 1'b1;
            end
            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 1'b1;
            end
            if (shift_en) begin
                sh <= {rx_s, sh[7:1]};
            end
            if (load) begin
                rx_data <= sh;
            end
        end
    end

    assign rx_bsy = (state != IDLE);

endmodule
